// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port between
// execute and memory writeback, with R15 diverted to a PC-write pulse.
module regfile_wr_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int PC_REG = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] A3,
   output logic [DATA_W-1:0] WD3,
   output logic              WE3,
   output logic              pc_wr,
   output logic [DATA_W-1:0] pc_wdata,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              fwd1,
   output logic              fwd2,
   output logic [DATA_W-1:0] fwd_data
);

   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_REG);

   logic              rr_q, rr_d;
   logic              we_q, we_d;
   logic              pcw_q, pcw_d;
   logic [ADDR_W-1:0] a3_q, a3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;
   logic [DATA_W-1:0] pcd_q, pcd_d;

   logic              open_w;
   logic              both;
   logic              gnt;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;

   assign open_w    = !rst && !hold;
   assign both      = ex_valid && mem_valid;
   assign ex_ready  = open_w && ex_valid && (!mem_valid || !rr_q);
   assign mem_ready = open_w && mem_valid && (!ex_valid || rr_q);
   assign gnt       = ex_ready || mem_ready;
   assign g_addr    = mem_ready ? mem_addr : ex_addr;
   assign g_data    = mem_ready ? mem_data : ex_data;

   always_comb begin
      rr_d  = rr_q;
      we_d  = 1'b0;
      pcw_d = 1'b0;
      a3_d  = a3_q;
      wd3_d = wd3_q;
      pcd_d = pcd_q;
      if (gnt) begin
         a3_d  = g_addr;
         wd3_d = g_data;
         // The pointer moves to the loser only when both were asking.
         if (both) rr_d = ex_ready;
         if (g_addr == PC_A) begin
            pcw_d = 1'b1;
            pcd_d = g_data;
         end else begin
            we_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q  <= 1'b0;
         we_q  <= 1'b0;
         pcw_q <= 1'b0;
         a3_q  <= '0;
         wd3_q <= '0;
         pcd_q <= '0;
      end else begin
         rr_q  <= rr_d;
         we_q  <= we_d;
         pcw_q <= pcw_d;
         a3_q  <= a3_d;
         wd3_q <= wd3_d;
         pcd_q <= pcd_d;
      end
   end

   assign A3       = a3_q;
   assign WD3      = wd3_q;
   assign WE3      = we_q;
   assign pc_wr    = pcw_q;
   assign pc_wdata = pcd_q;
   assign fwd1     = we_q && (a3_q == rd_addr1);
   assign fwd2     = we_q && (a3_q == rd_addr2);
   assign fwd_data = wd3_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus randomized bench for regfile_wr_arbiter against a
// transaction-level model of grants and the registered write port.
module tb_regfile_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst, hold;
   logic        ex_valid, ex_ready, mem_valid, mem_ready;
   logic [3:0]  ex_addr, mem_addr, A3, rd_addr1, rd_addr2;
   logic [31:0] ex_data, mem_data, WD3, pc_wdata, fwd_data;
   logic        WE3, pc_wr, fwd1, fwd2;

   int errors = 0;
   int checks = 0;

   // model state: who is favoured next contention, and last issued write
   int          fav;
   logic        m_we, m_pcwr;
   logic [3:0]  m_a3;
   logic [31:0] m_wd3, m_pcwd;
   int          last_win;

   regfile_wr_arbiter dut (
      .clk(clk), .rst(rst), .hold(hold),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_addr(ex_addr), .ex_data(ex_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .A3(A3), .WD3(WD3), .WE3(WE3),
      .pc_wr(pc_wr), .pc_wdata(pc_wdata),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // 0 = nobody, 1 = execute, 2 = memory
   function automatic int winner();
      if (rst || hold) return 0;
      if (ex_valid && mem_valid) return fav == 0 ? 1 : 2;
      if (ex_valid) return 1;
      if (mem_valid) return 2;
      return 0;
   endfunction

   task automatic check_all();
      int w;
      w = winner();
      chk("ex_ready", 32'(ex_ready), 32'(w == 1));
      chk("mem_ready", 32'(mem_ready), 32'(w == 2));
      chk("WE3", 32'(WE3), 32'(m_we));
      chk("pc_wr", 32'(pc_wr), 32'(m_pcwr));
      chk("A3", 32'(A3), 32'(m_a3));
      chk("WD3", WD3, m_wd3);
      chk("pc_wdata", pc_wdata, m_pcwd);
      chk("fwd1", 32'(fwd1), 32'(m_we && m_a3 == rd_addr1));
      chk("fwd2", 32'(fwd2), 32'(m_we && m_a3 == rd_addr2));
      chk("fwd_data", fwd_data, m_wd3);
   endtask

   task automatic model_edge(input int w);
      logic [3:0]  a;
      logic [31:0] d;
      last_win = w;
      if (rst) begin
         fav = 0; m_we = 0; m_pcwr = 0;
         m_a3 = 0; m_wd3 = 0; m_pcwd = 0;
         return;
      end
      m_we = 0; m_pcwr = 0;
      if (w == 0) return;
      a = (w == 1) ? ex_addr : mem_addr;
      d = (w == 1) ? ex_data : mem_data;
      if (ex_valid && mem_valid) fav = (w == 1) ? 1 : 0;
      m_a3 = a; m_wd3 = d;
      if (a == 4'hF) begin
         m_pcwr = 1; m_pcwd = d;
      end else begin
         m_we = 1;
      end
   endtask

   task automatic tick();
      int w;
      #2;
      check_all();
      w = winner();
      @(posedge clk);
      model_edge(w);
      #1;
   endtask

   initial begin
      rst = 1; hold = 0;
      ex_valid = 0; mem_valid = 0;
      ex_addr = 0; mem_addr = 0; ex_data = 0; mem_data = 0;
      rd_addr1 = 0; rd_addr2 = 0;
      fav = 0; m_we = 0; m_pcwr = 0;
      m_a3 = 0; m_wd3 = 0; m_pcwd = 0; last_win = 0;
      @(posedge clk); #1;

      // reset then idle
      ex_valid = 1; ex_addr = 4'h5; ex_data = 32'hDEAD;
      tick();
      ex_valid = 0;
      tick();
      rst = 0;
      chk("rst_WE3", 32'(WE3), 32'd0);
      chk("rst_A3", 32'(A3), 32'd0);
      chk("rst_WD3", WD3, 32'd0);
      tick();

      // single execute write
      ex_valid = 1; ex_addr = 4'h2; ex_data = 32'h87654321;
      #2 chk("single_ready", 32'(ex_ready), 32'd1);
      tick();
      ex_valid = 0;
      chk("single_WE3", 32'(WE3), 32'd1);
      chk("single_A3", 32'(A3), 32'd2);
      chk("single_WD3", WD3, 32'h87654321);
      tick();
      chk("single_WE3_off", 32'(WE3), 32'd0);

      // contention alternates ex, mem, ex, mem
      ex_valid = 1; ex_addr = 4'h1; ex_data = 32'h12345678;
      mem_valid = 1; mem_addr = 4'h3; mem_data = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_WE3", 32'(WE3), 32'd1);
         chk("rr_A3", 32'(A3), (i % 2 == 0) ? 32'd1 : 32'd3);
      end
      ex_valid = 0; mem_valid = 0;
      tick();

      // PC diversion
      mem_valid = 1; mem_addr = 4'hF; mem_data = 32'h10;
      rd_addr1 = 4'hF;
      tick();
      mem_valid = 0;
      chk("pc_pulse", 32'(pc_wr), 32'd1);
      chk("pc_data", pc_wdata, 32'h10);
      chk("pc_WE3", 32'(WE3), 32'd0);
      chk("pc_fwd1", 32'(fwd1), 32'd0);
      tick();
      chk("pc_pulse_off", 32'(pc_wr), 32'd0);

      // forwarding
      ex_valid = 1; ex_addr = 4'hE; ex_data = 32'h0000ABCD;
      rd_addr1 = 4'hE; rd_addr2 = 4'h1;
      tick();
      ex_valid = 0;
      chk("fwd1_hit", 32'(fwd1), 32'd1);
      chk("fwd2_miss", 32'(fwd2), 32'd0);
      chk("fwd_val", fwd_data, 32'h0000ABCD);
      tick();

      // one contended grant leaves memory favoured
      ex_valid = 1; mem_valid = 1; ex_addr = 4'h4; mem_addr = 4'h6;
      tick();
      // hold blocks everything
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         #2 chk("hold_exr", 32'(ex_ready), 32'd0);
         chk("hold_memr", 32'(mem_ready), 32'd0);
         tick();
         chk("hold_WE3", 32'(WE3), 32'd0);
      end
      hold = 0; rst = 1;
      tick();
      chk("rst_mid_WE3", 32'(WE3), 32'd0);
      rst = 0;
      #2 chk("rst_rr_ex", 32'(ex_ready), 32'd1);
      chk("rst_rr_mem", 32'(mem_ready), 32'd0);
      tick();
      ex_valid = 0; mem_valid = 0;
      tick();

      // randomized traffic honouring data stability while stalled
      for (int i = 0; i < 400; i++) begin
         logic ex_pend, mem_pend;
         ex_pend  = ex_valid && last_win != 1 && !rst;
         mem_pend = mem_valid && last_win != 2 && !rst;
         rst  = ($urandom_range(0, 39) == 0);
         hold = ($urandom_range(0, 7) == 0);
         if (!ex_pend) begin
            ex_valid = $urandom_range(0, 2) != 0;
            ex_addr  = 4'($urandom);
            ex_data  = $urandom;
         end
         if (!mem_pend) begin
            mem_valid = $urandom_range(0, 2) != 0;
            mem_addr  = 4'($urandom);
            mem_data  = $urandom;
         end
         rd_addr1 = 4'($urandom);
         rd_addr2 = ($urandom_range(0, 1) == 0) ? A3 : 4'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
